// File: rtl/cdb_broadcaster.sv
// cdb_broadcaster
//   Transmit end of the common data bus. Each functional unit pushes results
//   into its own small in-order FIFO. A round-robin arbiter picks one FIFO
//   head per cycle and drives it onto the registered broadcast outputs.
//
//   Ports
//     clk        system clock, all state updates on posedge
//     RST        asynchronous active-high reset
//     src_valid  per-source result valid
//     src_label  per-source producer tag, 4 bits each (tag 0 = no producer)
//     src_data   per-source result value, 32 bits each
//     src_ready  per-source "FIFO has room", a function of state only
//     BCEN       broadcast valid (registered)
//     BClabel    broadcast tag (registered, holds when idle)
//     BCdata     broadcast value (registered, holds when idle)
//     pending    some FIFO is non-empty
//     stall_cnt  saturating count of cycles with a refused valid
//                (present only when CDB_STALL_CNT_EN is defined)
//
//   Build option: define CDB_STALL_CNT_EN to add the stall_cnt output.
module cdb_broadcaster #(
    parameter int N_SRC = 3,
    parameter int DEPTH = 2
) (
    input  logic                 clk,
    input  logic                 RST,
    input  logic [N_SRC-1:0]     src_valid,
    input  logic [4*N_SRC-1:0]   src_label,
    input  logic [32*N_SRC-1:0]  src_data,
    output logic [N_SRC-1:0]     src_ready,
    output logic                 BCEN,
    output logic [3:0]           BClabel,
    output logic [31:0]          BCdata,
    output logic                 pending
`ifdef CDB_STALL_CNT_EN
    ,
    output logic [15:0]          stall_cnt
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int SW = $clog2(N_SRC);

    logic [3:0]    labelMem [N_SRC][DEPTH];
    logic [31:0]   dataMem  [N_SRC][DEPTH];
    logic [PW-1:0] rdPtr    [N_SRC];
    logic [PW-1:0] wrPtr    [N_SRC];
    logic [CW-1:0] count    [N_SRC];
    logic [SW-1:0] rrPtr;

    logic [N_SRC-1:0] notEmpty;
    logic [N_SRC-1:0] push;
    logic [N_SRC-1:0] pop;
    logic             found;
    logic [SW-1:0]    winner;
    logic [SW-1:0]    nextPtr;
    logic [3:0]       headLabel;
    logic [31:0]      headData;

    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            notEmpty[i]  = (count[i] != '0);
            src_ready[i] = (count[i] < CW'(DEPTH));
        end
    end

    assign pending = |notEmpty;

    // Rotating priority: start at rrPtr and take the first non-empty FIFO.
    always_comb begin
        int idx;
        idx    = 0;
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < N_SRC; k++) begin
            idx = int'(rrPtr) + k;
            if (idx >= N_SRC) idx = idx - N_SRC;
            if (!found && notEmpty[idx]) begin
                found  = 1'b1;
                winner = SW'(idx);
            end
        end
    end

    assign nextPtr   = (winner == SW'(N_SRC - 1)) ? '0 : winner + SW'(1);
    assign headLabel = labelMem[winner][rdPtr[winner]];
    assign headData  = dataMem[winner][rdPtr[winner]];

    // Tag 0 completes the handshake but is never stored, so it can never
    // reach the bus.
    always_comb begin
        for (int i = 0; i < N_SRC; i++) begin
            push[i] = src_valid[i] && src_ready[i] && (src_label[4*i +: 4] != 4'd0);
            pop[i]  = found && (winner == SW'(i));
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < N_SRC; i++) begin
            if (push[i]) begin
                labelMem[i][wrPtr[i]] <= src_label[4*i +: 4];
                dataMem[i][wrPtr[i]]  <= src_data[32*i +: 32];
            end
        end
    end

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            for (int i = 0; i < N_SRC; i++) begin
                rdPtr[i] <= '0;
                wrPtr[i] <= '0;
                count[i] <= '0;
            end
            rrPtr   <= '0;
            BCEN    <= 1'b0;
            BClabel <= 4'd0;
            BCdata  <= 32'd0;
        end else begin
            for (int i = 0; i < N_SRC; i++) begin
                if (push[i]) wrPtr[i] <= wrPtr[i] + PW'(1);
                if (pop[i])  rdPtr[i] <= rdPtr[i] + PW'(1);
                case ({push[i], pop[i]})
                    2'b10:   count[i] <= count[i] + CW'(1);
                    2'b01:   count[i] <= count[i] - CW'(1);
                    default: count[i] <= count[i];
                endcase
            end
            if (found) begin
                BCEN    <= 1'b1;
                BClabel <= headLabel;
                BCdata  <= headData;
                rrPtr   <= nextPtr;
            end else begin
                BCEN    <= 1'b0;
            end
        end
    end

`ifdef CDB_STALL_CNT_EN
    logic stallHit;
    assign stallHit = |(src_valid & ~src_ready);

    always_ff @(posedge clk or posedge RST) begin
        if (RST) begin
            stall_cnt <= 16'd0;
        end else if (stallHit && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: tb/tb_cdb_broadcaster.sv
// tb_cdb_broadcaster
//   Directed bench for cdb_broadcaster (N_SRC=3, DEPTH=2). Inputs change on
//   the falling edge; outputs are sampled on the falling edge after each
//   rising edge. Expected values are worked out by hand from the broadcast
//   rules (round-robin from the pointer, one pop per cycle, tag 0 dropped).
module tb_cdb_broadcaster;

    logic        clk;
    logic        RST;
    logic [2:0]  src_valid;
    logic [11:0] src_label;
    logic [95:0] src_data;
    logic [2:0]  src_ready;
    logic        BCEN;
    logic [3:0]  BClabel;
    logic [31:0] BCdata;
    logic        pending;
`ifdef CDB_STALL_CNT_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    cdb_broadcaster #(.N_SRC(3), .DEPTH(2)) dut (
        .clk       (clk),
        .RST       (RST),
        .src_valid (src_valid),
        .src_label (src_label),
        .src_data  (src_data),
        .src_ready (src_ready),
        .BCEN      (BCEN),
        .BClabel   (BClabel),
        .BCdata    (BCdata),
        .pending   (pending)
`ifdef CDB_STALL_CNT_EN
        ,
        .stall_cnt (stall_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic setSrc(input int i, input logic [3:0] lab, input logic [31:0] dat);
        src_label[4*i +: 4]   = lab;
        src_data[32*i +: 32]  = dat;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        RST       = 1'b1;
        src_valid = 3'b000;
        src_label = '0;
        src_data  = '0;
        @(negedge clk);
        @(negedge clk);

        // reset state
        chk("rst_bcen",    32'(BCEN),      0);
        chk("rst_label",   32'(BClabel),   0);
        chk("rst_data",    BCdata,         0);
        chk("rst_ready",   32'(src_ready), 32'h7);
        chk("rst_pending", 32'(pending),   0);
        RST = 1'b0;

        // single result from source 0
        setSrc(0, 4'd5, 32'h0000_00AA);
        src_valid = 3'b001;
        tick();
        src_valid = 3'b000;
        chk("single_buf_bcen", 32'(BCEN),    0);
        chk("single_buf_pend", 32'(pending), 1);
        tick();
        chk("single_bcen",  32'(BCEN),    1);
        chk("single_label", 32'(BClabel), 5);
        chk("single_data",  BCdata,       32'hAA);
        chk("single_pend",  32'(pending), 0);
        tick();
        chk("single_end_bcen",  32'(BCEN),    0);
        chk("single_hold_lab",  32'(BClabel), 5);
        chk("single_hold_data", BCdata,       32'hAA);

        // simultaneous results from all sources, starting at pointer 0
        RST = 1'b1;
        #1;
        RST = 1'b0;
        setSrc(0, 4'd4,  32'h100);
        setSrc(1, 4'd8,  32'h200);
        setSrc(2, 4'd12, 32'h300);
        src_valid = 3'b111;
        tick();
        src_valid = 3'b000;
        chk("sim_buf_bcen", 32'(BCEN), 0);
        tick();
        chk("sim_bc0_bcen", 32'(BCEN),    1);
        chk("sim_bc0_lab",  32'(BClabel), 4);
        chk("sim_bc0_data", BCdata,       32'h100);
        tick();
        chk("sim_bc1_bcen", 32'(BCEN),    1);
        chk("sim_bc1_lab",  32'(BClabel), 8);
        tick();
        chk("sim_bc2_bcen", 32'(BCEN),    1);
        chk("sim_bc2_lab",  32'(BClabel), 12);
        chk("sim_bc2_data", BCdata,       32'h300);
        chk("sim_bc2_pend", 32'(pending), 0);
        tick();
        chk("sim_end_bcen", 32'(BCEN), 0);

        // fairness and backpressure: source 0 streams, source 2 once.
        // Pointer is back at 0, so source 0 goes first.
        setSrc(0, 4'd1,  32'h1001);
        setSrc(2, 4'd15, 32'h002F);
        src_valid = 3'b101;
        chk("fair_ready0", 32'(src_ready), 32'h7);
        tick();
        chk("fair_c0_bcen",  32'(BCEN),      0);
        chk("fair_c0_pend",  32'(pending),   1);
        setSrc(0, 4'd2, 32'h1002);
        src_valid = 3'b001;
        tick();
        chk("fair_c1_lab",   32'(BClabel),   1);
        chk("fair_c1_data",  BCdata,         32'h1001);
        chk("fair_c1_ready", 32'(src_ready), 32'h7);
        setSrc(0, 4'd3, 32'h1003);
        tick();
        chk("fair_c2_lab",   32'(BClabel),   15);
        chk("fair_c2_data",  BCdata,         32'h2F);
        chk("fair_c2_ready", 32'(src_ready), 32'h6);
        setSrc(0, 4'd4, 32'h1004);
        tick();
        chk("fair_c3_lab",   32'(BClabel),   2);
        chk("fair_c3_data",  BCdata,         32'h1002);
        chk("fair_c3_ready", 32'(src_ready), 32'h7);
        tick();
        chk("fair_c4_bcen",  32'(BCEN),      1);
        chk("fair_c4_lab",   32'(BClabel),   3);
        src_valid = 3'b000;
        tick();
        chk("fair_c5_lab",   32'(BClabel),   4);
        chk("fair_c5_data",  BCdata,         32'h1004);
        chk("fair_c5_pend",  32'(pending),   0);
        tick();
        chk("fair_end_bcen", 32'(BCEN),      0);

        // reserved tag 0 is accepted and dropped
        setSrc(1, 4'd0, 32'h0000_DEAD);
        src_valid = 3'b010;
        chk("rsv_ready", 32'(src_ready[1]), 1);
        tick();
        src_valid = 3'b000;
        chk("rsv_pend0", 32'(pending), 0);
        chk("rsv_bcen0", 32'(BCEN),    0);
        tick();
        chk("rsv_bcen1", 32'(BCEN),    0);
        chk("rsv_hold",  32'(BClabel), 4);

        // reset mid-operation (pointer is at 1 here)
        setSrc(0, 4'd6, 32'h6006);
        setSrc(1, 4'd7, 32'h7007);
        src_valid = 3'b011;
        tick();
        setSrc(0, 4'd9,  32'h9009);
        setSrc(1, 4'd10, 32'hA00A);
        tick();
        src_valid = 3'b000;
        chk("mid_bcen", 32'(BCEN),    1);
        chk("mid_lab",  32'(BClabel), 7);
        chk("mid_data", BCdata,       32'h7007);
        chk("mid_pend", 32'(pending), 1);
        #2;
        RST = 1'b1;
        #1;
        chk("mid_rst_bcen",  32'(BCEN),      0);
        chk("mid_rst_pend",  32'(pending),   0);
        chk("mid_rst_lab",   32'(BClabel),   0);
        chk("mid_rst_ready", 32'(src_ready), 32'h7);
        @(negedge clk);
        RST = 1'b0;
        tick();
        chk("post_rst_bcen0", 32'(BCEN), 0);
        tick();
        chk("post_rst_bcen1", 32'(BCEN),    0);
        chk("post_rst_pend",  32'(pending), 0);

        // pointer was reset to 0: source 0 beats source 1
        setSrc(0, 4'd3,  32'h3333);
        setSrc(1, 4'd11, 32'hBBBB);
        src_valid = 3'b011;
        tick();
        src_valid = 3'b000;
        tick();
        chk("ptr0_first",  32'(BClabel), 3);
        tick();
        chk("ptr0_second", 32'(BClabel), 11);
        chk("ptr0_data",   BCdata,       32'hBBBB);
        tick();
        chk("ptr0_end",    32'(BCEN),    0);

`ifdef CDB_STALL_CNT_EN
        // all three sources saturate for 6 cycles; refusals on cycles 2..5
        RST = 1'b1;
        #1;
        RST = 1'b0;
        chk("stall_rst", 32'(stall_cnt), 0);
        setSrc(0, 4'd1, 32'h1);
        setSrc(1, 4'd2, 32'h2);
        setSrc(2, 4'd3, 32'h3);
        src_valid = 3'b111;
        tick();
        tick();
        chk("stall_c1", 32'(stall_cnt), 0);
        tick();
        chk("stall_c2", 32'(stall_cnt), 1);
        tick();
        tick();
        tick();
        chk("stall_c5", 32'(stall_cnt), 4);
        src_valid = 3'b000;
        tick();
        tick();
        chk("stall_hold", 32'(stall_cnt), 4);
        RST = 1'b1;
        #1;
        chk("stall_clr", 32'(stall_cnt), 0);
        @(negedge clk);
        RST = 1'b0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
